// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and result-entry type shared by the ALU writeback stage
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              z;
    logic              n;
    logic              c;
    logic              v;
    logic              err;
    logic [2:0]        op;
  } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational result select and Z/N/C/V/err flag derivation for one entry
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [2:0]   op,
  input  logic         a_msb,
  input  logic         b_msb,
  input  logic [W-1:0] add_res,
  input  logic         add_c,
  input  logic [W-1:0] sub_res,
  input  logic         sub_c,
  input  logic [W-1:0] and_res,
  input  logic [W-1:0] or_res,
  input  logic [W-1:0] xor_res,
  input  logic [W-1:0] slt_res,
  output alu_entry_t   entry
);

  logic [W-1:0] sel;
  logic         c;
  logic         v;
  logic         err;
  logic         add_ovf;
  logic         sub_ovf;

  assign add_ovf = (a_msb == b_msb) & (add_res[W-1] != a_msb);
  // SLT reuses the subtract overflow to flag an uncorrected sign bit; it is not fixed up here.
  assign sub_ovf = (a_msb != b_msb) & (sub_res[W-1] != a_msb);

  always_comb begin
    sel = '0;
    c   = 1'b0;
    v   = 1'b0;
    err = 1'b0;
    case (op)
      OP_ADD: begin sel = add_res; c = add_c; v = add_ovf; end
      OP_SUB: begin sel = sub_res; c = sub_c; v = sub_ovf; end
      OP_AND: sel = and_res;
      OP_OR:  sel = or_res;
      OP_XOR: sel = xor_res;
      OP_SLT: begin sel = slt_res; v = sub_ovf; end
      default: err = 1'b1;
    endcase
  end

  always_comb begin
    entry     = '0;
    entry.res = sel;
    entry.z   = (sel == '0);
    entry.n   = sel[W-1];
    entry.c   = c;
    entry.v   = v;
    entry.err = err;
    entry.op  = op;
  end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU writeback stage with skid buffer and SLT-true counter
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  input  logic [W-1:0]     add_res,
  input  logic             add_c,
  input  logic [W-1:0]     sub_res,
  input  logic             sub_c,
  input  logic [W-1:0]     and_res,
  input  logic [W-1:0]     or_res,
  input  logic [W-1:0]     xor_res,
  input  logic [W-1:0]     slt_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res,
  output logic             out_z,
  output logic             out_n,
  output logic             out_c,
  output logic             out_v,
  output logic             out_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] slt_cnt
);

  alu_entry_t       new_entry;
  alu_entry_t       out_q;
  alu_entry_t       skid_q;
  logic             out_valid_q;
  logic             skid_empty_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             deliver;
  logic             cnt_hit;

  alu_flag_gen #(.W(W)) u_flag_gen (
    .op      (in_op),
    .a_msb   (in_a_msb),
    .b_msb   (in_b_msb),
    .add_res (add_res),
    .add_c   (add_c),
    .sub_res (sub_res),
    .sub_c   (sub_c),
    .and_res (and_res),
    .or_res  (or_res),
    .xor_res (xor_res),
    .slt_res (slt_res),
    .entry   (new_entry)
  );

  assign accept  = in_valid & skid_empty_q;
  assign deliver = out_valid_q & out_ready;
  assign cnt_hit = deliver & (out_q.op == OP_SLT) & out_q.res[0];

  // in_ready is the skid-empty flop itself, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_empty_q <= 1'b1;
    end else if (deliver) begin
      if (!skid_empty_q) begin
        out_q        <= skid_q;
        skid_empty_q <= 1'b1;
      end else if (accept) begin
        out_q <= new_entry;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q) begin
        out_q       <= new_entry;
        out_valid_q <= 1'b1;
      end else begin
        skid_q       <= new_entry;
        skid_empty_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_cnt) begin
      cnt_q <= '0;
    end else if (cnt_hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready  = skid_empty_q;
  assign out_valid = out_valid_q;
  assign out_res   = out_q.res;
  assign out_z     = out_q.z;
  assign out_n     = out_q.n;
  assign out_c     = out_q.c;
  assign out_v     = out_q.v;
  assign out_err   = out_q.err;
  assign slt_cnt   = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - scoreboard bench for alu_result_stage with directed vectors
module tb_alu_result_stage;

  localparam int W     = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic             in_a_msb;
  logic             in_b_msb;
  logic [W-1:0]     add_res;
  logic             add_c;
  logic [W-1:0]     sub_res;
  logic             sub_c;
  logic [W-1:0]     and_res;
  logic [W-1:0]     or_res;
  logic [W-1:0]     xor_res;
  logic [W-1:0]     slt_res;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_res;
  logic             out_z;
  logic             out_n;
  logic             out_c;
  logic             out_v;
  logic             out_err;
  logic             clr_cnt;
  logic [CNT_W-1:0] slt_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [36:0] sb[$];

  alu_result_stage #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
    .add_res(add_res), .add_c(add_c), .sub_res(sub_res), .sub_c(sub_c),
    .and_res(and_res), .or_res(or_res), .xor_res(xor_res), .slt_res(slt_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_z(out_z), .out_n(out_n), .out_c(out_c), .out_v(out_v), .out_err(out_err),
    .clr_cnt(clr_cnt), .slt_cnt(slt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [36:0] e(input logic [31:0] r, input logic z, input logic n,
                                    input logic c, input logic v, input logic err);
    return {r, z, n, c, v, err};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Non-selected units carry distinct noise so a wrong select or leaked carry shows up.
  task automatic drive(input logic [2:0] op, input logic am, input logic bm,
                       input logic [31:0] r, input logic rc, input logic [31:0] sr);
    in_op = op; in_a_msb = am; in_b_msb = bm;
    add_res = 32'h1111_1111; add_c = 1'b1;
    sub_res = sr;            sub_c = 1'b1;
    and_res = 32'h3333_3333; or_res = 32'h4444_4444;
    xor_res = 32'h5555_5555; slt_res = 32'h0;
    case (op)
      3'd0: begin add_res = r; add_c = rc; end
      3'd1: sub_c = rc;
      3'd2: and_res = r;
      3'd3: or_res = r;
      3'd4: xor_res = r;
      3'd5: slt_res = r;
      default: add_res = r;
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic am, input logic bm,
                       input logic [31:0] r, input logic rc, input logic [31:0] sr,
                       input logic [36:0] exp);
    bit done = 0;
    drive(op, am, bm, r, rc, sr);
    in_valid = 1'b1;
    for (int t = 0; t < 30 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("issue_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [36:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out", 1, 0);
        else begin
          exp = sb.pop_front();
          check("result", {out_res, out_z, out_n, out_c, out_v, out_err}, exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    drive(3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #23;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out", {out_res, out_z, out_n, out_c, out_v, out_err}, 0);
    check("rst_cnt", slt_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    issue(3'd0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 32'h2222_2222, e(32'h8000_0000, 0, 1, 0, 1, 0));
    check("latency_valid", out_valid, 1);
    cycles(2);

    issue(3'd5, 1'b1, 1'b0, 32'h1, 1'b0, 32'hFFFF_FFFE, e(32'h1, 0, 0, 0, 0, 0));
    cycles(2);
    check("slt_cnt_1", slt_cnt, 1);
    issue(3'd5, 1'b1, 1'b0, 32'h0, 1'b0, 32'h7FFF_FFFF, e(32'h0, 1, 0, 0, 1, 0));
    cycles(2);
    check("slt_cnt_still_1", slt_cnt, 1);

    issue(3'd1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2, e(32'h2, 0, 0, 1, 0, 0));
    issue(3'd1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h7FFF_FFFF, e(32'h7FFF_FFFF, 0, 0, 1, 1, 0));
    issue(3'd2, 1'b1, 1'b1, 32'hF0F0_0000, 1'b0, 32'h0, e(32'hF0F0_0000, 0, 1, 0, 0, 0));
    issue(3'd3, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, e(32'h0, 1, 0, 0, 0, 0));
    issue(3'd4, 1'b1, 1'b0, 32'h1, 1'b0, 32'h7FFF_FFFF, e(32'h1, 0, 0, 0, 0, 0));
    issue(3'd6, 1'b0, 1'b0, 32'h1234, 1'b1, 32'h0, e(32'h0, 1, 0, 0, 0, 1));
    issue(3'd7, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0, e(32'h0, 1, 0, 0, 0, 1));
    issue(3'd0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0, e(32'h0, 1, 0, 1, 1, 0));
    cycles(3);

    // Back-pressure: two beats fill output and skid, third stalls.
    out_ready = 1'b0;
    issue(3'd0, 1'b0, 1'b0, 32'h1, 1'b0, 32'h0, e(32'h1, 0, 0, 0, 0, 0));
    check("bp_ready_after_1", in_ready, 1);
    issue(3'd0, 1'b0, 1'b0, 32'h2, 1'b0, 32'h0, e(32'h2, 0, 0, 0, 0, 0));
    check("bp_ready_after_2", in_ready, 0);
    drive(3'd0, 1'b0, 1'b0, 32'h3, 1'b0, 32'h0);
    in_valid = 1'b1;
    cycles(3);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_res", out_res, 32'h1);
    check("bp_still_blocked", in_ready, 0);
    out_ready = 1'b1;
    cycles(1);
    check("bp_ready_back", in_ready, 1);
    issue(3'd0, 1'b0, 1'b0, 32'h3, 1'b0, 32'h0, e(32'h3, 0, 0, 0, 0, 0));
    cycles(3);

    // Saturation (CNT_W=4): 14 more SLT-true deliveries reach 15, one more holds.
    for (int i = 0; i < 14; i++)
      issue(3'd5, 1'b1, 1'b0, 32'h1, 1'b0, 32'hFFFF_FFFE, e(32'h1, 0, 0, 0, 0, 0));
    cycles(2);
    check("cnt_at_max", slt_cnt, 15);
    issue(3'd5, 1'b1, 1'b0, 32'h1, 1'b0, 32'hFFFF_FFFE, e(32'h1, 0, 0, 0, 0, 0));
    cycles(2);
    check("cnt_saturated", slt_cnt, 15);

    issue(3'd5, 1'b1, 1'b0, 32'h1, 1'b0, 32'hFFFF_FFFE, e(32'h1, 0, 0, 0, 0, 0));
    clr_cnt = 1'b1;
    check("clr_same_cycle_valid", out_valid, 1);
    cycles(1);
    clr_cnt = 1'b0;
    check("clr_priority", slt_cnt, 0);
    issue(3'd5, 1'b1, 1'b0, 32'h1, 1'b0, 32'hFFFF_FFFE, e(32'h1, 0, 0, 0, 0, 0));
    cycles(2);
    check("cnt_after_clr", slt_cnt, 1);

    // Asynchronous reset with both entries full.
    out_ready = 1'b0;
    issue(3'd5, 1'b1, 1'b0, 32'h1, 1'b0, 32'hFFFF_FFFE, e(32'h1, 0, 0, 0, 0, 0));
    issue(3'd0, 1'b0, 1'b0, 32'h55, 1'b0, 32'h0, e(32'h55, 0, 0, 0, 0, 0));
    check("full_before_reset", in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_cnt", slt_cnt, 0);
    check("arst_out_res", out_res, 0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    cycles(3);
    check("no_stale_after_reset", out_valid, 0);
    issue(3'd2, 1'b0, 1'b0, 32'h0000_00A5, 1'b0, 32'h0, e(32'h0000_00A5, 0, 0, 0, 0, 0));
    cycles(3);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
